// File: rtl/calc1_port_driver.sv
// Host-side driver for the calc1 request/response port: issues CMD then DATA, waits for a response or timeout.
// Optional statistics counters are compiled in with `define CALC1_DRV_STATS_EN.
module calc1_port_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        c_clk,
  input  logic        reset,
`ifdef CALC1_DRV_STATS_EN
  output logic [15:0] stat_issued,
  output logic [15:0] stat_ok,
  output logic [15:0] stat_err,
  output logic [15:0] stat_timeout,
  output logic [15:0] stat_spurious,
`endif
  input  logic        txn_valid,
  output logic        txn_ready,
  input  logic [0:3]  txn_cmd,
  input  logic [0:31] txn_op1,
  input  logic [0:31] txn_op2,
  output logic [0:3]  req_cmd_out,
  output logic [0:31] req_data_out,
  input  logic [0:1]  out_resp,
  input  logic [0:31] out_data,
  output logic        rsp_valid,
  output logic [0:1]  rsp_code,
  output logic [0:31] rsp_data,
  output logic        rsp_timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DATA,
    S_WAIT,
    S_DONE
  } state_t;

  // The counter's value during the final permitted WAIT cycle.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [0:3]  cmd_q;
  logic [0:31] op1_q, op2_q;
  logic [7:0]  wait_cnt;

  logic resp_seen, wait_expired;
  assign resp_seen    = (out_resp != 2'd0);
  assign wait_expired = (wait_cnt == LAST_CNT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    txn_ready    = 1'b0;
    req_cmd_out  = '0;
    req_data_out = '0;
    rsp_valid    = 1'b0;
    case (state)
      S_IDLE: begin
        txn_ready = 1'b1;
        if (txn_valid) state_nxt = (txn_cmd != 4'd0) ? S_CMD : S_DONE;
      end
      S_CMD: begin
        req_cmd_out  = cmd_q;
        req_data_out = op1_q;
        state_nxt    = S_DATA;
      end
      S_DATA: begin
        req_data_out = op2_q;
        state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        if (resp_seen || wait_expired) state_nxt = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Transaction latches, WAIT counter and the response registers that persist until the next DONE.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      cmd_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      wait_cnt    <= '0;
      rsp_code    <= '0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (txn_valid) begin
            cmd_q <= txn_cmd;
            op1_q <= txn_op1;
            op2_q <= txn_op2;
            if (txn_cmd == 4'd0) begin
              rsp_code    <= '0;
              rsp_data    <= '0;
              rsp_timeout <= 1'b0;
            end
          end
        end
        S_DATA: wait_cnt <= '0;
        S_WAIT: begin
          // A response wins over an expiry landing on the same edge.
          if (resp_seen) begin
            rsp_code    <= out_resp;
            rsp_data    <= out_data;
            rsp_timeout <= 1'b0;
          end else if (wait_expired) begin
            rsp_code    <= '0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CALC1_DRV_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      stat_issued   <= '0;
      stat_ok       <= '0;
      stat_err      <= '0;
      stat_timeout  <= '0;
      stat_spurious <= '0;
    end else begin
      if (state == S_IDLE && txn_valid && txn_cmd != 4'd0) stat_issued <= sat_inc(stat_issued);
      if (state == S_WAIT && out_resp == 2'd1)             stat_ok     <= sat_inc(stat_ok);
      if (state == S_WAIT && out_resp[0])                  stat_err    <= sat_inc(stat_err);
      if (state == S_WAIT && !resp_seen && wait_expired)   stat_timeout <= sat_inc(stat_timeout);
      if (state != S_WAIT && resp_seen)                    stat_spurious <= sat_inc(stat_spurious);
    end
  end
`endif

endmodule

// File: tb/tb_calc1_port_driver.sv
// Directed-vector bench for calc1_port_driver (default build, TIMEOUT_CYCLES=4).
module tb_calc1_port_driver;

  localparam int TMO = 4;

  logic        c_clk;
  logic        reset;
  logic        txn_valid;
  logic        txn_ready;
  logic [0:3]  txn_cmd;
  logic [0:31] txn_op1, txn_op2;
  logic [0:3]  req_cmd_out;
  logic [0:31] req_data_out;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        rsp_valid;
  logic [0:1]  rsp_code;
  logic [0:31] rsp_data;
  logic        rsp_timeout;

  calc1_port_driver #(.TIMEOUT_CYCLES(TMO)) dut (
    .c_clk       (c_clk),
    .reset       (reset),
    .txn_valid   (txn_valid),
    .txn_ready   (txn_ready),
    .txn_cmd     (txn_cmd),
    .txn_op1     (txn_op1),
    .txn_op2     (txn_op2),
    .req_cmd_out (req_cmd_out),
    .req_data_out(req_data_out),
    .out_resp    (out_resp),
    .out_data    (out_data),
    .rsp_valid   (rsp_valid),
    .rsp_code    (rsp_code),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  // Issue one transaction; the responder answers in WAIT cycle resp_at (0 = never).
  task automatic run_txn(input string tag, input logic [3:0] cmd, input logic [31:0] op1,
                         input logic [31:0] op2, input int resp_at, input logic [1:0] code,
                         input logic [31:0] data, input int exp_wait, input logic [1:0] exp_code,
                         input logic [31:0] exp_data, input logic exp_to);
    int seen;
    seen = 0;
    check({tag, ".ready"}, 32'(txn_ready), 32'd1);
    txn_valid = 1'b1; txn_cmd = cmd; txn_op1 = op1; txn_op2 = op2;
    tick();
    txn_valid = 1'b0; txn_cmd = '0; txn_op1 = '0; txn_op2 = '0;
    check({tag, ".cmd_phase_cmd"},  32'(req_cmd_out), 32'(cmd));
    check({tag, ".cmd_phase_data"}, 32'(req_data_out), op1);
    check({tag, ".busy"}, 32'(txn_ready), 32'd0);
    tick();
    check({tag, ".data_phase_cmd"},  32'(req_cmd_out), 32'd0);
    check({tag, ".data_phase_data"}, 32'(req_data_out), op2);
    tick();
    for (int w = 1; w <= 20 && seen == 0; w++) begin
      if (w == 1) begin
        check({tag, ".wait_cmd"},  32'(req_cmd_out), 32'd0);
        check({tag, ".wait_data"}, 32'(req_data_out), 32'd0);
      end
      if (w == resp_at) begin
        out_resp = code; out_data = data;
      end
      tick();
      out_resp = '0; out_data = '0;
      if (rsp_valid) seen = w;
    end
    check({tag, ".wait_cycles"}, 32'(seen), 32'(exp_wait));
    check({tag, ".code"},    32'(rsp_code), 32'(exp_code));
    check({tag, ".data"},    32'(rsp_data), exp_data);
    check({tag, ".timeout"}, 32'(rsp_timeout), 32'(exp_to));
    tick();
    check({tag, ".pulse_end"}, 32'(rsp_valid), 32'd0);
    check({tag, ".hold_data"}, 32'(rsp_data), exp_data);
    check({tag, ".idle_ready"}, 32'(txn_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; txn_valid = 1'b0; txn_cmd = '0; txn_op1 = '0; txn_op2 = '0;
    out_resp = '0; out_data = '0;
    #1;
    check("rst.ready",   32'(txn_ready), 32'd1);
    check("rst.valid",   32'(rsp_valid), 32'd0);
    check("rst.cmd",     32'(req_cmd_out), 32'd0);
    check("rst.data",    32'(req_data_out), 32'd0);
    check("rst.code",    32'(rsp_code), 32'd0);
    check("rst.rdata",   32'(rsp_data), 32'd0);
    check("rst.timeout", 32'(rsp_timeout), 32'd0);
    repeat (2) @(posedge c_clk);
    #2 reset = 1'b1;
    tick();

    run_txn("add",     4'd1, 32'd5, 32'd7,  3, 2'd1, 32'd12,       3, 2'd1, 32'd12,       1'b0);
    run_txn("sub",     4'd2, 32'd3, 32'd10, 2, 2'd1, 32'd7,        2, 2'd1, 32'd7,        1'b0);
    run_txn("tmo",     4'd1, 32'd1, 32'd2,  0, 2'd0, 32'd0,      TMO, 2'd0, 32'd0,        1'b1);
    run_txn("tie",     4'd6, 32'd4, 32'd1,TMO, 2'd3, 32'hDEAD, TMO, 2'd3, 32'hDEAD,     1'b0);
    run_txn("lsh",     4'd5, 32'd8, 32'd2,  1, 2'd2, 32'h20,       1, 2'd2, 32'h20,       1'b0);

    // A response while idle must change nothing.
    out_resp = 2'd1; out_data = 32'h55;
    tick();
    out_resp = '0; out_data = '0;
    check("spur.ready", 32'(txn_ready), 32'd1);
    check("spur.valid", 32'(rsp_valid), 32'd0);
    check("spur.code",  32'(rsp_code), 32'd2);
    check("spur.data",  32'(rsp_data), 32'h20);

    // NOP goes straight to DONE.
    txn_valid = 1'b1; txn_cmd = 4'd0; txn_op1 = 32'd9; txn_op2 = 32'd9;
    tick();
    txn_valid = 1'b0;
    check("nop.valid",   32'(rsp_valid), 32'd1);
    check("nop.cmd",     32'(req_cmd_out), 32'd0);
    check("nop.code",    32'(rsp_code), 32'd0);
    check("nop.timeout", 32'(rsp_timeout), 32'd0);
    check("nop.ready",   32'(txn_ready), 32'd0);
    tick();
    check("nop.after_valid", 32'(rsp_valid), 32'd0);
    check("nop.after_ready", 32'(txn_ready), 32'd1);
    check("nop.after_cmd",   32'(req_cmd_out), 32'd0);

    // Reset in the middle of WAIT aborts the transaction.
    txn_valid = 1'b1; txn_cmd = 4'd1; txn_op1 = 32'd9; txn_op2 = 32'd9;
    tick();
    txn_valid = 1'b0;
    tick();
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    check("mid_rst.ready", 32'(txn_ready), 32'd1);
    check("mid_rst.valid", 32'(rsp_valid), 32'd0);
    check("mid_rst.cmd",   32'(req_cmd_out), 32'd0);
    check("mid_rst.data",  32'(req_data_out), 32'd0);
    out_resp = 2'd1; out_data = 32'h77;
    tick();
    out_resp = '0; out_data = '0;
    check("mid_rst.no_pulse", 32'(rsp_valid), 32'd0);
    check("mid_rst.code",     32'(rsp_code), 32'd0);
    #2 reset = 1'b1;
    tick();
    check("mid_rst.after_valid", 32'(rsp_valid), 32'd0);
    run_txn("post_rst", 4'd1, 32'd1, 32'd1, 1, 2'd1, 32'd2, 1, 2'd1, 32'd2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
